// File: rtl/reg_lock_pkg.sv
// reg_lock_pkg: protection modes and per-register mode lookup for reg_lock_bank
package reg_lock_pkg;
  typedef enum logic [1:0] {MODE_RW, MODE_WO, MODE_LOCK_CMD, MODE_RSVD} reg_mode_e;
  function automatic reg_mode_e mode_of(input logic [31:0] modes, input int i);
    return reg_mode_e'(modes[2*i +: 2]);
  endfunction
endpackage

// File: rtl/reg_lock_slot.sv
// reg_lock_slot: one protected register and its one-way lock flag
module reg_lock_slot
  import reg_lock_pkg::*;
#(
  parameter int W = 16,
  parameter reg_mode_e MODE = MODE_WO,
  parameter logic [W-1:0] RESET_VAL = '0,
  parameter bit STATUS_LSB = 1'b1
) (
  input  logic         Clk,
  input  logic         ip_resetn,
  input  logic         global_resetn,
  input  logic         wr,
  input  logic         lk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         locked
);
  localparam bit ST = STATUS_LSB && (MODE == MODE_WO || MODE == MODE_LOCK_CMD);
  localparam logic [W-1:0] MASK = ST ? ~W'(1) : '1;
  logic [W-1:0] val;
  // the lock survives the soft reset; only ip_resetn can clear it
  always_ff @(posedge Clk or negedge ip_resetn)
    if (!ip_resetn) begin
      val <= RESET_VAL;
      locked <= 1'b0;
    end else if (!global_resetn) val <= RESET_VAL;
    else begin
      if (wr && !locked) val <= d & MASK;
      if ((wr && !locked && MODE == MODE_WO) || (lk && MODE == MODE_LOCK_CMD)) locked <= 1'b1;
    end
  assign q = ST ? {val[W-1:1], locked} : val;
endmodule

// File: rtl/reg_lock_bank.sv
// reg_lock_bank: bank of protected config registers with write handshake and violation counter
module reg_lock_bank
  import reg_lock_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W = 4,
  parameter logic [2*NUM_REGS-1:0] MODE = {NUM_REGS{2'b01}},
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0,
  parameter bit STATUS_LSB = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic                       Clk,
  input  logic                       ip_resetn,
  input  logic                       global_resetn,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       lock_req,
  input  logic                       viol_clr,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       wr_ack,
  output logic                       wr_err,
  output logic [NUM_REGS-1:0]        lock_status,
  output logic [NUM_REGS*DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]           viol_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0] valid_pad, lock_pad;
  logic [DATA_W-1:0] rd_mux [DEPTH];
  logic hit, accept, viol;
  logic [CNT_W-1:0] cnt_base;
  // address space is padded so out-of-range addresses decode as invalid/zero
  assign valid_pad = DEPTH'({NUM_REGS{1'b1}});
  assign lock_pad = DEPTH'(lock_status);
  assign hit = wr_en && global_resetn;
  assign accept = hit && valid_pad[wr_addr] && !lock_pad[wr_addr];
  assign viol = hit && !accept;
  assign cnt_base = viol_clr ? '0 : viol_cnt;
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    if (g < NUM_REGS) begin : g_slot
      reg_lock_slot #(
        .W(DATA_W),
        .MODE(mode_of(32'(MODE), g)),
        .RESET_VAL(RESET_VAL[g*DATA_W +: DATA_W]),
        .STATUS_LSB(STATUS_LSB)
      ) u_slot (
        .Clk(Clk),
        .ip_resetn(ip_resetn),
        .global_resetn(global_resetn),
        .wr(accept && wr_addr == ADDR_W'(g)),
        .lk(lock_req && global_resetn && wr_addr == ADDR_W'(g)),
        .d(wr_data),
        .q(data_out[g*DATA_W +: DATA_W]),
        .locked(lock_status[g])
      );
      assign rd_mux[g] = data_out[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign rd_mux[g] = '0;
    end
  end
  always_ff @(posedge Clk or negedge ip_resetn)
    if (!ip_resetn) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      rd_data <= '0;
      viol_cnt <= '0;
    end else begin
      wr_ack <= accept;
      wr_err <= viol;
      rd_data <= rd_mux[rd_addr];
      viol_cnt <= cnt_base + CNT_W'(viol && cnt_base != '1);
    end
endmodule

// File: tb/tb_reg_lock_bank.sv
// tb_reg_lock_bank: directed checks of protection modes, resets, handshake and counter
module tb_reg_lock_bank;
  logic Clk = 1'b0, ip_resetn = 1'b0, global_resetn = 1'b1;
  logic wr_en = 1'b0, lock_req = 1'b0, viol_clr = 1'b0;
  logic [3:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0, rd_data;
  logic wr_ack, wr_err;
  logic [3:0] lock_status;
  logic [63:0] data_out;
  logic [7:0] viol_cnt;
  int checks = 0, errors = 0;

  reg_lock_bank #(.MODE(8'b01_00_10_01)) dut (
    .Clk(Clk), .ip_resetn(ip_resetn), .global_resetn(global_resetn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .lock_req(lock_req),
    .viol_clr(viol_clr), .rd_addr(rd_addr), .rd_data(rd_data), .wr_ack(wr_ack),
    .wr_err(wr_err), .lock_status(lock_status), .data_out(data_out), .viol_cnt(viol_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic lk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; lock_req = lk;
    @(negedge Clk);
    wr_en = 1'b0; lock_req = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_data", data_out, 64'h0);
    chk("rst_lock", lock_status, 4'h0);
    chk("rst_cnt", viol_cnt, 8'd0);
    chk("rst_hs", {wr_ack, wr_err}, 2'b00);
    chk("rst_rd", rd_data, 16'h0);
    ip_resetn = 1'b1;
    @(negedge Clk);
    wr(4'd0, 16'h1235, 1'b0);
    chk("wo_ack", {wr_ack, wr_err}, 2'b10);
    chk("wo_data", data_out[15:0], 16'h1235);
    chk("wo_lock", lock_status[0], 1'b1);
    wr(4'd0, 16'hFFFF, 1'b0);
    chk("wo2_err", {wr_ack, wr_err}, 2'b01);
    chk("wo2_data", data_out[15:0], 16'h1235);
    chk("wo2_cnt", viol_cnt, 8'd1);
    @(negedge Clk);
    chk("hs_pulse", {wr_ack, wr_err}, 2'b00);
    wr(4'd1, 16'hA0A0, 1'b0);
    chk("lc_ack", {wr_ack, wr_err}, 2'b10);
    chk("lc_data", data_out[31:16], 16'hA0A0);
    chk("lc_unlk", lock_status[1], 1'b0);
    lock_req = 1'b1; wr_addr = 4'd1;
    @(negedge Clk);
    lock_req = 1'b0;
    chk("lc_lock", lock_status[1], 1'b1);
    chk("lc_lock_hs", {wr_ack, wr_err}, 2'b00);
    wr(4'd1, 16'h0001, 1'b0);
    chk("lc_err", {wr_ack, wr_err}, 2'b01);
    chk("lc_data2", data_out[31:16], 16'hA0A1);
    chk("lc_cnt", viol_cnt, 8'd2);
    lock_req = 1'b1; wr_addr = 4'd2;
    @(negedge Clk);
    lock_req = 1'b0;
    chk("rw_nolock", lock_status, 4'b0011);
    global_resetn = 1'b0;
    wr(4'd2, 16'h5555, 1'b0);
    global_resetn = 1'b1;
    chk("sr_hs", {wr_ack, wr_err}, 2'b00);
    chk("sr_data", data_out, 64'h0000_0000_0001_0001);
    chk("sr_lock", lock_status, 4'b0011);
    chk("sr_cnt", viol_cnt, 8'd2);
    wr(4'd0, 16'h4444, 1'b0);
    chk("sr_err", {wr_ack, wr_err}, 2'b01);
    chk("sr_cnt2", viol_cnt, 8'd3);
    ip_resetn = 1'b0;
    #1;
    chk("ipr_data", data_out, 64'h0);
    chk("ipr_lock", lock_status, 4'h0);
    chk("ipr_cnt", viol_cnt, 8'd0);
    @(negedge Clk);
    ip_resetn = 1'b1;
    @(negedge Clk);
    wr(4'd0, 16'h00F0, 1'b0);
    chk("ipr_ack", {wr_ack, wr_err}, 2'b10);
    chk("ipr_wdata", data_out[15:0], 16'h00F1);
    wr(4'd1, 16'h1230, 1'b1);
    chk("wl_ack", {wr_ack, wr_err}, 2'b10);
    chk("wl_data", data_out[31:16], 16'h1231);
    chk("wl_lock", lock_status, 4'b0011);
    wr(4'd7, 16'hBEEF, 1'b0);
    chk("inv_err", {wr_ack, wr_err}, 2'b01);
    chk("inv_data", data_out, 64'h0000_0000_1231_00F1);
    chk("inv_cnt", viol_cnt, 8'd1);
    wr_en = 1'b1; wr_addr = 4'd7;
    repeat (300) @(negedge Clk);
    wr_en = 1'b0;
    chk("sat_cnt", viol_cnt, 8'd255);
    viol_clr = 1'b1;
    wr(4'd7, 16'h0, 1'b0);
    viol_clr = 1'b0;
    chk("clr_viol", viol_cnt, 8'd1);
    viol_clr = 1'b1;
    @(negedge Clk);
    viol_clr = 1'b0;
    chk("clr_only", viol_cnt, 8'd0);
    wr(4'd2, 16'h1111, 1'b0);
    chk("rw_ack1", {wr_ack, wr_err}, 2'b10);
    wr(4'd2, 16'h2222, 1'b0);
    chk("rw_ack2", {wr_ack, wr_err}, 2'b10);
    rd_addr = 4'd2;
    @(negedge Clk);
    chk("rw_rd", rd_data, 16'h2222);
    chk("rw_lock", lock_status[2], 1'b0);
    wr(4'd2, 16'h3333, 1'b0);
    chk("rw_rd_pre", rd_data, 16'h2222);
    chk("rw_data3", data_out[47:32], 16'h3333);
    rd_addr = 4'd0;
    @(negedge Clk);
    chk("rd_reg0", rd_data, 16'h00F1);
    rd_addr = 4'd9;
    @(negedge Clk);
    chk("rd_inv", rd_data, 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
